// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: constants, exception codes and the IF/ID payload type shared by
// the fetch unit, its IF/ID register and the interface.
package fetch_unit_pkg;

    // Default address map
    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] HANDLER_PC = 32'h0000_1180;
    localparam logic [31:0] IM_LIMIT   = 32'h0000_1FFF;

    // Fetch exception codes
    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;

    // Word placed in IF/ID for bubbles and faulting fetches
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    // One IF/ID slot
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        valid;
        logic        bd;
        logic [4:0]  exccode;
    } ifid_t;

    localparam ifid_t IFID_BUBBLE = '{
        instr:   NOP_WORD,
        pc:      32'h0000_0000,
        valid:   1'b0,
        bd:      1'b0,
        exccode: EXC_NONE
    };

    // A fetch faults when the address is not word aligned or lies past the
    // end of instruction memory.
    function automatic logic fetch_fault(input logic [31:0] addr, input logic [31:0] limit);
        return (addr[1:0] != 2'b00) || (addr > limit);
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: bundle between the fetch stage and the rest of the pipeline.
//   master (fetch unit): drives pc and the IF/ID contents D_*; receives the
//                        pipeline control inputs and the instruction word.
//   slave  (pipeline)  : the mirror image.
// Signals:
//   stall, redirect, redirect_pc, id_is_jump : decode-stage control
//   exc_req, eret, epc                       : CP0 control
//   instr_in                                 : instruction memory read data for pc
//   pc                                       : fetch address to instruction memory
//   D_instr, D_pc, D_valid, D_bd, D_exccode  : IF/ID register contents
interface fetch_unit_if;

    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_is_jump;
    logic        exc_req;
    logic        eret;
    logic [31:0] epc;
    logic [31:0] instr_in;

    logic [31:0] pc;
    logic [31:0] D_instr;
    logic [31:0] D_pc;
    logic        D_valid;
    logic        D_bd;
    logic [4:0]  D_exccode;

    modport master (
        input  stall, redirect, redirect_pc, id_is_jump, exc_req, eret, epc, instr_in,
        output pc, D_instr, D_pc, D_valid, D_bd, D_exccode
    );

    modport slave (
        output stall, redirect, redirect_pc, id_is_jump, exc_req, eret, epc, instr_in,
        input  pc, D_instr, D_pc, D_valid, D_bd, D_exccode
    );

endinterface

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register.
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous active-high reset, loads a bubble
//   en    : load d (ignored when flush or reset is high)
//   flush : load a bubble
//   d     : incoming slot contents
//   q     : registered slot contents
module if_id_reg
    import fetch_unit_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  en,
    input  logic  flush,
    input  ifid_t d,
    output ifid_t q
);

    // Flush wins over enable so a squashed slot can never be loaded while stalled.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            q <= IFID_BUBBLE;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Holds the PC, selects the next PC and
// captures each fetch (or its address fault) into the IF/ID register.
// Parameters:
//   RESET_PC   : first fetch address after reset
//   HANDLER_PC : exception handler entry
//   IM_LIMIT   : highest legal instruction byte address
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous active-high reset
//   bus   : fetch_unit_if master modport (control in, pc and IF/ID out)
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = fetch_unit_pkg::RESET_PC,
    parameter logic [31:0] HANDLER_PC = fetch_unit_pkg::HANDLER_PC,
    parameter logic [31:0] IM_LIMIT   = fetch_unit_pkg::IM_LIMIT
) (
    input  logic          clk,
    input  logic          reset,
    fetch_unit_if.master  bus
);

    import fetch_unit_pkg::*;

    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic        fault;
    logic        slot_bd;
    logic        ifid_en;
    logic        ifid_flush;
    ifid_t       fetch_slot;
    ifid_t       ifid_q;

    assign fault = fetch_fault(pc_q, IM_LIMIT);

    // Next-PC selection: exception > eret > stall > redirect > sequential.
    // exc_req/eret flush IF/ID even under stall; stall drops any redirect,
    // decode re-asserts it once the stall clears.
    always_comb begin
        pc_d       = pc_q;
        ifid_en    = 1'b0;
        ifid_flush = 1'b0;
        slot_bd    = 1'b0;
        if (bus.exc_req) begin
            pc_d       = HANDLER_PC;
            ifid_flush = 1'b1;
        end else if (bus.eret) begin
            pc_d       = bus.epc;
            ifid_flush = 1'b1;
        end else if (bus.stall) begin
            pc_d = pc_q;
        end else if (bus.redirect) begin
            // The word fetched this cycle is the branch delay slot.
            pc_d    = bus.redirect_pc;
            ifid_en = 1'b1;
            slot_bd = 1'b1;
        end else begin
            pc_d    = pc_q + 32'd4;
            ifid_en = 1'b1;
            slot_bd = bus.id_is_jump;
        end
    end

    // A faulting fetch still occupies a valid slot so the fault is raised in order.
    always_comb begin
        fetch_slot         = IFID_BUBBLE;
        fetch_slot.pc      = pc_q;
        fetch_slot.valid   = 1'b1;
        fetch_slot.bd      = slot_bd;
        fetch_slot.instr   = fault ? NOP_WORD : bus.instr_in;
        fetch_slot.exccode = fault ? EXC_ADEL : EXC_NONE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    if_id_reg u_if_id_reg (
        .clk   (clk),
        .reset (reset),
        .en    (ifid_en),
        .flush (ifid_flush),
        .d     (fetch_slot),
        .q     (ifid_q)
    );

    assign bus.pc        = pc_q;
    assign bus.D_instr   = ifid_q.instr;
    assign bus.D_pc      = ifid_q.pc;
    assign bus.D_valid   = ifid_q.valid;
    assign bus.D_bd      = ifid_q.bd;
    assign bus.D_exccode = ifid_q.exccode;

endmodule
